// File: rtl/sha_job_scheduler_if.sv
// Avalon-MM control-slave bus between the job scheduler and the SHA-256 accelerator.
// One access per cycle; read data returns in the cycle after the read strobe.
interface sha_job_scheduler_if;
  logic        chip_select;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output chip_select, write, read, address, wr_data,
    input  rd_data
  );

  modport slave (
    input  chip_select, write, read, address, wr_data,
    output rd_data
  );
endinterface

// File: rtl/sha_job_scheduler.sv
// Round-robin front end that shares one SHA-256 accelerator between NUM_REQ clients:
// programs a job over the control bus, polls for completion, and reports the cycle count.
module sha_job_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 2**20
) (
  input  logic                   iClk,
  input  logic                   iRstn,
  input  logic [NUM_REQ-1:0]     iReq,
  input  logic [32*NUM_REQ-1:0]  iReadAddr,
  input  logic [32*NUM_REQ-1:0]  iWriteAddr,
  input  logic [32*NUM_REQ-1:0]  iLength,
  output logic [NUM_REQ-1:0]     oGrant,
  output logic [NUM_REQ-1:0]     oDone,
  output logic [NUM_REQ-1:0]     oError,
  output logic                   oBusy,
  output logic [31:0]            oShaCycles,
  sha_job_scheduler_if.master    ctrl
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [31:0] CTRL_RESET = 32'h0;
  localparam logic [31:0] CTRL_FLUSH = 32'h5;
  localparam logic [31:0] CTRL_START = 32'h3;

  typedef enum logic [3:0] {
    IDLE, CHECK, CFG_RST, CFG_RADDR, CFG_WADDR, CFG_LEN, CFG_FLUSH, CFG_START,
    POLL_WAIT, POLL_RD, POLL_CHK, CYC_RD, CYC_CHK, RELEASE, ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, rr_q, pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] served_q, eligible, cur_onehot;
  logic [31:0]        raddr_q, waddr_q, len_q, cur_len;
  logic [31:0]        gap_q, tmo_q;
  logic               len_ok, tmo_hit, clr_gap, finish_ok, finish_err;

  assign eligible   = iReq & ~served_q;
  assign cur_onehot = NUM_REQ'(1) << idx_q;
  assign cur_len    = iLength[idx_q*32 +: 32];
  assign len_ok     = (cur_len != 32'd0) && (cur_len[5:0] == 6'd0);
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT - 1));

  // Scan from the farthest candidate back to rr so the nearest eligible index wins.
  always_comb begin
    int c;
    c          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = (int'(rr_q) + k) % NUM_REQ;
      if (eligible[c]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(c);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    clr_gap          = 1'b0;
    finish_ok        = 1'b0;
    finish_err       = 1'b0;
    ctrl.chip_select = 1'b0;
    ctrl.write       = 1'b0;
    ctrl.read        = 1'b0;
    ctrl.address     = 3'd0;
    ctrl.wr_data     = 32'd0;
    unique case (state_q)
      IDLE:      if (pick_valid) state_d = CHECK;
      CHECK: begin
        if (len_ok) state_d = CFG_RST;
        else begin
          finish_err = 1'b1;
          state_d    = IDLE;
        end
      end
      CFG_RST:   begin ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd0; ctrl.wr_data = CTRL_RESET; state_d = CFG_RADDR; end
      CFG_RADDR: begin ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd1; ctrl.wr_data = raddr_q;    state_d = CFG_WADDR; end
      CFG_WADDR: begin ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd2; ctrl.wr_data = waddr_q;    state_d = CFG_LEN;   end
      CFG_LEN:   begin ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd3; ctrl.wr_data = len_q;      state_d = CFG_FLUSH; end
      CFG_FLUSH: begin ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd0; ctrl.wr_data = CTRL_FLUSH; state_d = CFG_START; end
      CFG_START: begin
        ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd0; ctrl.wr_data = CTRL_START;
        clr_gap = 1'b1;
        state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (tmo_hit)                           state_d = ABORT;
        else if (gap_q == 32'(POLL_GAP - 1))   state_d = POLL_RD;
      end
      POLL_RD: begin
        ctrl.chip_select = 1'b1; ctrl.read = 1'b1; ctrl.address = 3'd4;
        state_d = tmo_hit ? ABORT : POLL_CHK;
      end
      // Status arrives one cycle after the strobe, so it is only trusted here.
      POLL_CHK: begin
        if (ctrl.rd_data[4] && ctrl.rd_data[5]) state_d = CYC_RD;
        else if (tmo_hit)                        state_d = ABORT;
        else begin
          clr_gap = 1'b1;
          state_d = POLL_WAIT;
        end
      end
      CYC_RD:    begin ctrl.chip_select = 1'b1; ctrl.read = 1'b1; ctrl.address = 3'd5; state_d = CYC_CHK; end
      CYC_CHK:   state_d = RELEASE;
      RELEASE: begin
        ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd0; ctrl.wr_data = CTRL_RESET;
        finish_ok = 1'b1;
        state_d   = IDLE;
      end
      ABORT: begin
        ctrl.chip_select = 1'b1; ctrl.write = 1'b1; ctrl.address = 3'd0; ctrl.wr_data = CTRL_RESET;
        finish_err = 1'b1;
        state_d    = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: registers use <= so every update sees the pre-edge values of its neighbours.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_q       <= '0;
      served_q   <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      oShaCycles <= '0;
      oDone      <= '0;
      oError     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) idx_q <= pick_idx;
      if (state_q == CHECK) begin
        raddr_q <= iReadAddr[idx_q*32 +: 32];
        waddr_q <= iWriteAddr[idx_q*32 +: 32];
        len_q   <= cur_len;
      end
      if (clr_gap)                  gap_q <= '0;
      else if (state_q == POLL_WAIT) gap_q <= gap_q + 32'd1;
      if (state_q == CFG_START) tmo_q <= '0;
      else if (state_q inside {POLL_WAIT, POLL_RD, POLL_CHK}) tmo_q <= tmo_q + 32'd1;
      if (state_q == CYC_CHK) oShaCycles <= ctrl.rd_data;
      oDone    <= finish_ok  ? cur_onehot : '0;
      oError   <= finish_err ? cur_onehot : '0;
      served_q <= (served_q & iReq) | ((finish_ok || finish_err) ? cur_onehot : '0);
      if (finish_ok || finish_err)
        rr_q <= (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign oBusy  = (state_q != IDLE) && (state_q != CHECK);
  assign oGrant = oBusy ? cur_onehot : '0;

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Scoreboard bench for sha_job_scheduler: stimulus queues expected bus writes, grants and
// completion pulses; a monitor pops and compares them as the DUT produces them.
module tb_sha_job_scheduler;
  localparam int NR  = 4;
  localparam int GAP = 4;
  localparam int TMO = 200;
  localparam logic [31:0] STALE   = 32'h0000_0030;
  localparam logic [31:0] CYC_KEY = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req = '0;
  logic [32*NR-1:0] raddr = '0, waddr = '0, len = '0;
  logic [NR-1:0]    grant, done, err;
  logic             busy;
  logic [31:0]      sha_cyc;

  sha_job_scheduler_if bus ();

  sha_job_scheduler #(.NUM_REQ(NR), .POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
    .iClk(clk), .iRstn(rstn), .iReq(req),
    .iReadAddr(raddr), .iWriteAddr(waddr), .iLength(len),
    .oGrant(grant), .oDone(done), .oError(err), .oBusy(busy),
    .oShaCycles(sha_cyc), .ctrl(bus)
  );

  typedef struct { logic [2:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit is_err; int idx; int polls; logic [31:0] cycles; int at_cyc; } evt_t;

  wr_t  exp_wr[$];
  evt_t exp_evt[$];
  int   exp_grant[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic unexpected(input string name);
    total++;
    $display("FAIL %s: activity seen with nothing expected (t=%0t)", name, $time);
  endtask

  // Accelerator model: answers status/cycle reads one cycle late, stale value otherwise.
  int          polls_needed = 1;
  logic [31:0] busy_status  = '0;
  int          poll_cnt     = 0;
  logic [31:0] seen_raddr   = '0;
  bit          rsp_pend     = 1'b0;
  logic [31:0] rsp_val      = '0;

  always @(negedge clk) begin
    if (bus.chip_select && bus.write) begin
      if (bus.address == 3'd1) seen_raddr = bus.wr_data;
      if (bus.address == 3'd0 && bus.wr_data == 32'h3) poll_cnt = 0;
    end
    if (bus.chip_select && bus.read) begin
      rsp_pend = 1'b1;
      if (bus.address == 3'd4) begin
        poll_cnt++;
        rsp_val = (poll_cnt >= polls_needed) ? 32'h30 : busy_status;
      end else if (bus.address == 3'd5) rsp_val = seen_raddr ^ CYC_KEY;
      else rsp_val = 32'hBAD0_0000;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.rd_data = rsp_pend ? rsp_val : STALE;
    rsp_pend = 1'b0;
  end

  // Monitor
  logic [NR-1:0] prev_grant = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.chip_select && bus.write) begin
        if (exp_wr.size() == 0) unexpected("bus_write");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.address), 32'(w.addr));
          check("wr_data", bus.wr_data, w.data);
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        if (exp_grant.size() == 0) unexpected("grant");
        else begin
          int g;
          g = exp_grant.pop_front();
          check("grant", 32'(grant), 32'(1) << g);
          check("busy_with_grant", 32'(busy), 32'd1);
        end
      end
      if (done != '0 || err != '0) begin
        if (exp_evt.size() == 0) unexpected("done_or_error");
        else begin
          evt_t e;
          e = exp_evt.pop_front();
          check("done_vec", 32'(done), e.is_err ? 32'd0 : (32'(1) << e.idx));
          check("err_vec",  32'(err),  e.is_err ? (32'(1) << e.idx) : 32'd0);
          if (!e.is_err) begin
            check("sha_cycles", sha_cyc, e.cycles);
            check("poll_count", 32'(poll_cnt), 32'(e.polls));
          end
          if (e.at_cyc >= 0) check("pulse_cycle", 32'(cyc), 32'(e.at_cyc));
        end
      end
    end
    prev_grant = grant;
  end

  task automatic set_desc(input int i, input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] ln);
    raddr[32*i +: 32] = ra;
    waddr[32*i +: 32] = wa;
    len[32*i +: 32]   = ln;
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_evt(input bit is_err, input int i, input int polls, input logic [31:0] c, input int at);
    evt_t e;
    e.is_err = is_err; e.idx = i; e.polls = polls; e.cycles = c; e.at_cyc = at;
    exp_evt.push_back(e);
  endtask

  // mode 0: completes, 1: times out, 2: cut short by reset after start
  task automatic push_job(input int i, input logic [31:0] ra, input logic [31:0] wa,
                          input logic [31:0] ln, input int polls, input int mode);
    exp_grant.push_back(i);
    push_wr(3'd0, 32'h0); push_wr(3'd1, ra); push_wr(3'd2, wa);
    push_wr(3'd3, ln);    push_wr(3'd0, 32'h5); push_wr(3'd0, 32'h3);
    if (mode != 2) push_wr(3'd0, 32'h0);
    if (mode == 0) push_evt(1'b0, i, polls, ra ^ CYC_KEY, -1);
    if (mode == 1) push_evt(1'b1, i, 0, '0, -1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() + exp_evt.size() + exp_grant.size()) != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(exp_wr.size() + exp_evt.size() + exp_grant.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    bus.rd_data = STALE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_cycles", sha_cyc,   32'd0);
    check("rst_cs",    32'(bus.chip_select), 32'd0);
    rstn = 1'b1;

    // 1: single job, done on third poll; descriptor change and req drop mid-job are ignored
    polls_needed = 3; busy_status = 32'h0;
    set_desc(0, 32'h1000, 32'h2000, 32'd64);
    push_job(0, 32'h1000, 32'h2000, 32'd64, 3, 0);
    @(posedge clk); #1;
    req[0] = 1'b1;
    begin
      int n;
      n = 0;
      while (grant == '0 && n < 50) begin @(posedge clk); #1; n++; end
      check("t1_grant_seen", 32'(grant != '0), 32'd1);
    end
    set_desc(0, 32'hFFFF_0000, 32'hEEEE_0000, 32'd128);
    req[0] = 1'b0;
    drain("t1_drain", 500);

    // 2: round robin 0..3 from reset, no regrant of a served request until it toggles
    pulse_reset();
    polls_needed = 1;
    for (int i = 0; i < NR; i++) begin
      set_desc(i, 32'h1_0000 * (i + 1), 32'h2_0000 + 32'h100 * i, 32'd64 * (i + 1));
      push_job(i, 32'h1_0000 * (i + 1), 32'h2_0000 + 32'h100 * i, 32'd64 * (i + 1), 1, 0);
    end
    req = '1;
    drain("t2_drain", 1000);
    repeat (30) @(posedge clk);
    #1;
    req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_job(0, 32'h1_0000, 32'h2_0000, 32'd64, 1, 0);
    req[0] = 1'b1;
    drain("t2_regrant", 500);
    req = '0;
    repeat (2) @(posedge clk);

    // 3: bad length on req2 rejected without bus traffic, req3 served next
    set_desc(2, 32'h3000, 32'h3400, 32'd100);
    set_desc(3, 32'h4000, 32'h4400, 32'd128);
    @(posedge clk); #1;
    push_evt(1'b1, 2, 0, '0, cyc + 2);
    push_job(3, 32'h4000, 32'h4400, 32'd128, 1, 0);
    req[2] = 1'b1; req[3] = 1'b1;
    drain("t3_drain", 500);
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // 4: timeout on req1, which stays held; rr moves on to 2 then 0
    polls_needed = 100000; busy_status = 32'h02;
    set_desc(1, 32'h5000, 32'h5400, 32'd256);
    push_job(1, 32'h5000, 32'h5400, 32'd256, 0, 1);
    req[1] = 1'b1;
    drain("t4_timeout", 1000);
    polls_needed = 2;
    set_desc(2, 32'h5800, 32'h5C00, 32'd64);
    set_desc(0, 32'h5900, 32'h5D00, 32'd192);
    push_job(2, 32'h5800, 32'h5C00, 32'd64, 2, 0);
    push_job(0, 32'h5900, 32'h5D00, 32'd192, 2, 0);
    req[0] = 1'b1; req[2] = 1'b1;
    drain("t4_next", 1000);
    repeat (20) @(posedge clk);
    #1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // 5: async reset while polling, then the same request restarts from CFG_RST
    polls_needed = 100000; busy_status = 32'h0;
    set_desc(3, 32'h6000, 32'h6400, 32'd64);
    push_job(3, 32'h6000, 32'h6400, 32'd64, 0, 2);
    req[3] = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_wr.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      check("t5_started", 32'(exp_wr.size()), 32'd0);
    end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("t5_grant",  32'(grant), 32'd0);
    check("t5_busy",   32'(busy),  32'd0);
    check("t5_done",   32'(done | err), 32'd0);
    check("t5_cycles", sha_cyc, 32'd0);
    check("t5_bus",    32'({bus.chip_select, bus.write, bus.read, bus.address}), 32'd0);
    check("t5_wdata",  bus.wr_data, 32'd0);
    @(posedge clk); #1;
    polls_needed = 1;
    push_job(3, 32'h6000, 32'h6400, 32'd64, 1, 0);
    rstn = 1'b1;
    drain("t5_restart", 500);
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // 6: status[4] alone is not completion; stale read data is never sampled
    busy_status = 32'h10; polls_needed = 3;
    set_desc(1, 32'h7000, 32'h7400, 32'h40);
    push_job(1, 32'h7000, 32'h7400, 32'h40, 3, 0);
    req[1] = 1'b1;
    drain("t6_drain", 500);
    req = '0;
    repeat (10) @(posedge clk);
    #1;
    check("cycles_held", sha_cyc, 32'h7000 ^ CYC_KEY);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
